// File: rtl/epp_cmd_ctrl.sv
// EPP command controller: register map behind the EPP data port, a command FIFO,
// and a one-at-a-time dispatcher to the GPU engine (valid/ready, then wait for done).
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no command outstanding; pops the FIFO head when enabled
// ST_ISSUE | cmd_valid high, cmd_data held until the engine takes it
// ST_WAIT  | command accepted, waiting for the engine's cmd_done pulse
module epp_cmd_ctrl #(
    parameter int FIFO_AW = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  epp_addr,
    input  logic [7:0]  epp_wdata,
    input  logic        epp_wr,
    input  logic        epp_rd,
    output logic [7:0]  epp_rdata,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [55:0] cmd_data,
    input  logic        cmd_done
);

    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [5:0][7:0]      args_q;
    logic [7:0]           opcode_q;
    logic                 enable_q;
    logic                 overflow_q, overflow_d;
    logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]     count_q, count_d;
    logic [55:0]          fifo_mem [DEPTH];
    logic [55:0]          cmd_data_q;
    logic [7:0]           rdata_q, rdata_d;

    logic wr_status, push_req, wr_ctrl, flush;
    logic full, empty, pop, push_ok, ovf_set;
    logic [7:0] status_byte;

    assign wr_status = epp_wr && (epp_addr == 8'h00);
    assign push_req  = epp_wr && (epp_addr == 8'h07);
    assign wr_ctrl   = epp_wr && (epp_addr == 8'h08);
    assign flush     = wr_ctrl && epp_wdata[1];

    // Count tops out at exactly DEPTH, so its MSB alone flags full.
    assign full  = count_q[FIFO_AW];
    assign empty = (count_q == '0);

    assign pop     = (state_q == ST_IDLE) && enable_q && !empty;
    assign push_ok = push_req && !flush && (!full || pop);
    assign ovf_set = push_req && !flush && full && !pop;

    assign status_byte = {1'b0, 3'(count_q), overflow_q, (state_q != ST_IDLE), empty, full};

    assign cmd_valid = (state_q == ST_ISSUE);
    assign cmd_data  = cmd_data_q;
    assign epp_rdata = rdata_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (pop)       state_d = ST_ISSUE;
            ST_ISSUE: if (cmd_ready) state_d = ST_WAIT;
            ST_WAIT:  if (cmd_done)  state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
            unique case ({push_ok, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Set beats clear when both land in the same cycle.
    always_comb begin
        overflow_d = overflow_q;
        if (ovf_set)
            overflow_d = 1'b1;
        else if (wr_status && epp_wdata[3])
            overflow_d = 1'b0;
    end

    always_comb begin
        rdata_d = 8'h00;
        unique case (epp_addr)
            8'h00:   rdata_d = status_byte;
            8'h01:   rdata_d = args_q[0];
            8'h02:   rdata_d = args_q[1];
            8'h03:   rdata_d = args_q[2];
            8'h04:   rdata_d = args_q[3];
            8'h05:   rdata_d = args_q[4];
            8'h06:   rdata_d = args_q[5];
            8'h07:   rdata_d = opcode_q;
            8'h08:   rdata_d = {7'b0, enable_q};
            default: rdata_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            args_q     <= '0;
            opcode_q   <= 8'h00;
            enable_q   <= 1'b0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            cmd_data_q <= '0;
            rdata_q    <= 8'h00;
        end else begin
            state_q    <= state_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            for (int i = 0; i < 6; i++) begin
                if (epp_wr && (epp_addr == 8'(i + 1)))
                    args_q[i] <= epp_wdata;
            end
            if (push_req)
                opcode_q <= epp_wdata;
            if (wr_ctrl)
                enable_q <= epp_wdata[0];
            if (pop)
                cmd_data_q <= fifo_mem[rd_ptr_q];
            if (epp_rd)
                rdata_q <= rdata_d;
        end
    end

    // Storage needs no reset; pointers and count define what is valid.
    // When full with a simultaneous pop, wr_ptr equals rd_ptr and the pop
    // still captures the old head because both happen on the same edge.
    always_ff @(posedge clk) begin
        if (push_ok)
            fifo_mem[wr_ptr_q] <= {epp_wdata, args_q};
    end

endmodule

// File: tb/tb_epp_cmd_ctrl.sv
// Scoreboard bench for epp_cmd_ctrl: expected read bytes and dispatched commands are
// queued by the stimulus and checked by a negedge monitor when the DUT presents them.
module tb_epp_cmd_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  epp_addr;
    logic [7:0]  epp_wdata;
    logic        epp_wr;
    logic        epp_rd;
    logic [7:0]  epp_rdata;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [55:0] cmd_data;
    logic        cmd_done;

    epp_cmd_ctrl #(.FIFO_AW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .epp_addr  (epp_addr),
        .epp_wdata (epp_wdata),
        .epp_wr    (epp_wr),
        .epp_rd    (epp_rd),
        .epp_rdata (epp_rdata),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .cmd_done  (cmd_done)
    );

    always #5 clk = ~clk;

    localparam logic [47:0] ARGS = 48'h665544332211;

    int n_checks = 0;
    int n_pass   = 0;
    int hs_count = 0;
    bit rd_pend  = 1'b0;
    logic [7:0]  rd_exp_q  [$];
    logic [55:0] cmd_exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: a read seen at one negedge is compared at the following negedge.
    always @(negedge clk) begin
        if (rd_pend) begin
            if (rd_exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL epp_rdata_unexpected: got 0x%0h, expected no read", epp_rdata);
            end else begin
                check("epp_rdata", 64'(epp_rdata), 64'(rd_exp_q.pop_front()));
            end
        end
        rd_pend = epp_rd && !rst;
        if (cmd_valid && cmd_ready && !rst) begin
            hs_count++;
            if (cmd_exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL cmd_unexpected: got 0x%0h, expected no command", cmd_data);
            end else begin
                check("cmd_data", 64'(cmd_data), 64'(cmd_exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic epp_write(input logic [7:0] a, input logic [7:0] d);
        epp_addr  = a;
        epp_wdata = d;
        epp_wr    = 1'b1;
        tick();
        epp_wr    = 1'b0;
    endtask

    task automatic epp_read(input logic [7:0] a, input logic [7:0] exp);
        rd_exp_q.push_back(exp);
        epp_addr = a;
        epp_rd   = 1'b1;
        tick();
        epp_rd   = 1'b0;
    endtask

    task automatic pulse_done();
        cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 20 && !cmd_valid; i++) tick();
        check(name, 64'(cmd_valid), 64'd1);
    endtask

    task automatic wait_hs(input int target);
        for (int i = 0; i < 50 && hs_count < target; i++) tick();
        check("handshake_count", 64'(hs_count), 64'(target));
    endtask

    initial begin
        bit seen;
        rst = 1'b1; epp_addr = 8'h00; epp_wdata = 8'h00;
        epp_wr = 1'b0; epp_rd = 1'b0; cmd_ready = 1'b0; cmd_done = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_cmd_valid", 64'(cmd_valid), 64'd0);
        check("reset_cmd_data",  64'(cmd_data),  64'd0);
        check("reset_epp_rdata", 64'(epp_rdata), 64'd0);
        rst = 1'b0;
        tick();

        // 1: first command, held until enable
        epp_read(8'h00, 8'h02);
        for (int i = 0; i < 6; i++) epp_write(8'(i + 1), 8'(8'h11 * (i + 1)));
        epp_write(8'h07, 8'hA5);
        epp_read(8'h00, 8'h10);
        epp_read(8'h03, 8'h33);
        epp_read(8'h07, 8'hA5);
        cmd_exp_q.push_back({8'hA5, ARGS});
        epp_write(8'h08, 8'h01);
        wait_valid("valid_rise_t1");

        // 2: hold under back-pressure, then accept and complete
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_valid", 64'(cmd_valid), 64'd1);
            check("hold_data",  64'(cmd_data),  64'h00A5_6655_4433_2211);
        end
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        check("valid_fall", 64'(cmd_valid), 64'd0);
        epp_read(8'h00, 8'h06);
        pulse_done();
        epp_read(8'h00, 8'h02);

        // 3: overflow with dispatch disabled, then W1C
        epp_write(8'h08, 8'h00);
        for (int k = 0; k < 5; k++) epp_write(8'h07, 8'(8'hB1 + k));
        for (int k = 0; k < 4; k++) cmd_exp_q.push_back({8'(8'hB1 + k), ARGS});
        epp_read(8'h00, 8'h49);
        epp_write(8'h00, 8'h08);
        epp_read(8'h00, 8'h41);

        // 4: push on the pop cycle while full, drain across pointer wrap
        cmd_ready = 1'b1;
        cmd_exp_q.push_back({8'hB6, ARGS});
        epp_write(8'h08, 8'h01);
        epp_write(8'h07, 8'hB6);
        epp_read(8'h00, 8'h45);
        for (int k = 1; k <= 5; k++) begin
            wait_hs(1 + k);
            pulse_done();
        end
        cmd_ready = 1'b0;
        epp_read(8'h00, 8'h02);

        // 5: flush leaves the in-flight command alone
        cmd_exp_q.push_back({8'hC1, ARGS});
        for (int k = 0; k < 4; k++) epp_write(8'h07, 8'(8'hC1 + k));
        epp_read(8'h00, 8'h34);
        epp_write(8'h08, 8'h03);
        epp_read(8'h00, 8'h06);
        epp_read(8'h08, 8'h01);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        wait_hs(7);
        pulse_done();
        cmd_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (cmd_valid) seen = 1'b1;
        end
        cmd_ready = 1'b0;
        check("no_redispatch", 64'(seen), 64'd0);
        epp_read(8'h00, 8'h02);

        // 6: asynchronous reset during ISSUE
        epp_write(8'h01, 8'h77);
        epp_write(8'h07, 8'hD1);
        wait_valid("valid_rise_t6");
        #2 rst = 1'b1;
        #1;
        check("async_drop_valid", 64'(cmd_valid), 64'd0);
        check("async_drop_data",  64'(cmd_data),  64'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        tick();
        epp_read(8'h00, 8'h02);
        epp_read(8'h01, 8'h00);
        epp_read(8'h08, 8'h00);

        // Read and write of the same register in one cycle returns the old value
        rd_exp_q.push_back(8'h00);
        epp_addr = 8'h02; epp_wdata = 8'h5A; epp_wr = 1'b1; epp_rd = 1'b1;
        tick();
        epp_wr = 1'b0; epp_rd = 1'b0;
        epp_read(8'h02, 8'h5A);
        epp_read(8'h09, 8'h00);

        repeat (3) tick();
        check("rd_queue_drained",  64'(rd_exp_q.size()),  64'd0);
        check("cmd_queue_drained", 64'(cmd_exp_q.size()), 64'd0);
        check("total_handshakes",  64'(hs_count),         64'd7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/epp_cmd_ctrl.md
Name: epp_cmd_ctrl

Overview:
Command controller behind the EPP byte interface of the GPU. It decodes EPP data-register accesses into a small register map and assembles a 6-byte argument block plus opcode into 56-bit commands. Commands are queued in a FIFO and dispatched one at a time to the GPU engine with a valid/ready handshake, waiting for completion before the next dispatch. Status is readable by the PC over EPP.

Parameters:
FIFO_AW, 2, log2 of command FIFO depth; legal values 1..2, so the depth is 2 or 4.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
epp_addr  in  8  latched EPP address register
epp_wdata  in  8  EPP write byte
epp_wr  in  1  one-cycle pulse: data write to epp_addr
epp_rd  in  1  one-cycle pulse: data read from epp_addr
epp_rdata  out  8  read byte, registered
cmd_valid  out  1  command offered to engine
cmd_ready  in  1  engine accepts command
cmd_data  out  56  {opcode[55:48], arg5..arg0}, arg0 in [7:0]
cmd_done  in  1  one-cycle pulse: engine finished current command

Behaviour:
- Register map (all other addresses read 0x00; writes to them are ignored):
  - 0x00 STATUS (RO, except W1C on bit3). bit0 full, bit1 empty, bit2 in_flight (dispatch state != IDLE), bit3 overflow (sticky), bits6:4 FIFO count, bit7 = 0.
  - 0x01..0x06 ARG0..ARG5 (R/W): byte registers.
  - 0x07 OPCODE (W): writing pushes {wdata, ARG5..ARG0} into the FIFO. Reads return the last opcode written.
  - 0x08 CTRL (R/W). bit0 enable: dispatch is allowed only when it is 1. bit1 flush: self-clearing, always reads 0.
- Reset: all args, opcode and CTRL = 0, FIFO empty, overflow = 0, epp_rdata = 0x00, cmd_valid = 0, cmd_data = 0, state IDLE.
- Reads: epp_rdata updates on the clock edge after epp_rd and holds until the next epp_rd. STATUS reads sample the values before that same edge.
- Push: accepted if count < depth, or if a pop occurs in the same cycle. Otherwise the command is dropped and overflow is set.
  - An ARG write followed by an OPCODE write on the next cycle must capture the new ARG value.
- Overflow clear: writing 0x00 with bit3 = 1 clears overflow. If a set and a clear happen in the same cycle, set wins.
- Flush (CTRL write with bit1 = 1): FIFO count becomes 0 next cycle. A push in the same cycle is discarded without setting overflow. The in-flight command is unaffected.
- Dispatch FSM:
  - IDLE: if enable and FIFO not empty, pop the head into the cmd_data register and go to ISSUE. cmd_valid = 1 from the next cycle.
  - ISSUE: hold cmd_valid and cmd_data stable until cmd_ready is sampled high. Then cmd_valid = 0 the next cycle; go to WAIT.
  - WAIT: on cmd_done go to IDLE. A cmd_done in any other state is ignored.
  - A new dispatch can start in the cycle after returning to IDLE, so the minimum spacing between cmd_valid rises is 3 cycles.
  - Clearing enable does not abort ISSUE or WAIT. It only blocks the next pop.
- FIFO pointers wrap modulo depth. Count is FIFO_AW+1 bits.
- epp_rd and epp_wr in the same cycle are both serviced. A read of a register being written returns the old value.
- rst asserted mid-operation drops cmd_valid immediately (asynchronously) and discards all queued and in-flight commands.

Test Plan:
1. Reset, then read 0x00 -> 0x02 (empty). Write ARG0..5 = 0x11..0x66, OPCODE = 0xA5 with enable = 0 -> STATUS = 0x10. Set CTRL = 0x01 -> cmd_valid rises with cmd_data = 0xA5_665544332211.
2. Hold cmd_ready = 0 for 5 cycles -> cmd_valid and cmd_data stable. Pulse cmd_ready -> cmd_valid falls next cycle and STATUS bit2 = 1. Pulse cmd_done -> STATUS bit2 = 0.
3. enable = 0, push 5 opcodes with FIFO_AW = 2 -> STATUS = 0x49 (count 4, full, overflow). Write 0x08 to 0x00 -> STATUS = 0x41.
4. FIFO full, enable = 1, cmd_ready tied 1, push on the pop cycle -> push accepted, overflow stays 0. Opcodes dispatch in FIFO order across pointer wrap.
5. Queue 3 commands, then write CTRL = 0x03 -> count = 0 and no further cmd_valid after the current command completes. CTRL reads 0x01.
6. Assert rst during ISSUE -> cmd_valid = 0 without a clock edge. After release, STATUS = 0x02 and ARG0 reads 0x00.
